// File: rtl/port_type_source.sv
// Burst record source: on start, emits `count` indexed records through a
// valid/ready handshake, then pulses done for one cycle.

typedef struct packed {
    int a;
} user_int_t;

module port_type_source #(
    parameter int  CNT_W  = 16,
    parameter real F_STEP = 0.5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  int               seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output var  bit          a,
    output wire logic        b,
    output var  int          d,
    output var  user_int_t   s,
    output wire integer      e,
    output var  int          h,
    output var  int          i [1],
    output var  real         f,
    output var  int          g [2]
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic        a;
        logic        b;
        logic [31:0] d;
        logic [31:0] sa;
        logic [31:0] e;
        logic [31:0] h;
        logic [31:0] g0;
        logic [31:0] g1;
    } rec_t;

    state_t           state;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] cnt_lat;
    logic [31:0]      seed_lat;
    rec_t             rec;

    function automatic rec_t make_rec(input logic [31:0] kk, input logic [31:0] sd);
        rec_t r;
        r.a  = kk[0];
        r.b  = kk[1];
        r.d  = sd + kk;
        r.sa = sd ^ kk;
        r.e  = 32'd0 - kk;
        r.h  = kk * 32'd3;
        r.g0 = kk;
        r.g1 = ~kk;
        return r;
    endfunction

    // Record fields are registered alongside the index they describe, so the
    // outputs change only on a transfer and stay stable through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            cnt_lat   <= '0;
            seed_lat  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            rec       <= '0;
            f         <= 0.0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (count != '0) begin
                            cnt_lat   <= count;
                            seed_lat  <= seed;
                            k         <= '0;
                            out_valid <= 1'b1;
                            rec       <= make_rec(32'd0, seed);
                            f         <= 0.0;
                            state     <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (k == cnt_lat - CNT_W'(1)) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            rec       <= '0;
                            f         <= 0.0;
                            state     <= DONE;
                        end else begin
                            k   <= k + CNT_W'(1);
                            rec <= make_rec(32'(k) + 32'd1, seed_lat);
                            f   <= real'(32'(k) + 32'd1) * F_STEP;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    rec       <= '0;
                    f         <= 0.0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign a    = rec.a;
    assign b    = rec.b;
    assign d    = rec.d;
    assign s    = '{a: rec.sa};
    assign e    = rec.e;
    assign h    = rec.h;
    assign i[0] = rec.d;
    assign g[0] = rec.g0;
    assign g[1] = rec.g1;

endmodule

// File: tb/tb_port_type_source.sv
// Directed bench for port_type_source (CNT_W=4 so a full-range burst is short).

module tb_port_type_source;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  count;
    int          seed;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    bit          a;
    logic        b;
    int          d;
    user_int_t   s;
    integer      e;
    int          h;
    int          i_o [1];
    real         f;
    int          g [2];

    int total = 0;
    int bad   = 0;

    port_type_source #(.CNT_W(4), .F_STEP(0.5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready), .done(done),
        .a(a), .b(b), .d(d), .s(s), .e(e), .h(h), .i(i_o), .f(f), .g(g)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [3:0] c, input int sd);
        start = 1'b1;
        count = c;
        seed  = sd;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        step();
        total++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_ctl valid=%b done=%b exp 0 0", out_valid, done);
        end
        total++;
        if (d !== 0 || e !== 0 || h !== 0 || s.a !== 0 || g[1] !== 0 || i_o[0] !== 0 || a !== 1'b0 || b !== 1'b0 || f != 0.0) begin
            bad++; $display("FAIL reset_data d=%h e=%h h=%h g1=%h f=%f exp all 0", d, e, h, g[1], f);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int  exp_d  [3] = '{100, 101, 102};
        int  exp_e  [3] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        real exp_f  [3] = '{0.0, 0.5, 1.0};
        int  exp_g1 [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        int  exp_h  [3] = '{0, 3, 6};
        bit  exp_a  [3] = '{1'b0, 1'b1, 1'b0};
        bit  exp_b  [3] = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        kick(4'd3, 100);
        for (int j = 0; j < 3; j++) begin
            total++;
            if (out_valid !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL basic_valid k=%0d valid=%b done=%b exp 1 0", j, out_valid, done);
            end
            total++;
            if (d !== exp_d[j] || i_o[0] !== exp_d[j] || e !== exp_e[j] || g[1] !== exp_g1[j] || g[0] !== j) begin
                bad++; $display("FAIL basic_int k=%0d d=%h i0=%h e=%h g0=%h g1=%h exp d=%h e=%h g1=%h",
                                j, d, i_o[0], e, g[0], g[1], exp_d[j], exp_e[j], exp_g1[j]);
            end
            total++;
            if (f != exp_f[j] || h !== exp_h[j] || a !== exp_a[j] || b !== exp_b[j]) begin
                bad++; $display("FAIL basic_misc k=%0d f=%f h=%0d a=%b b=%b exp f=%f h=%0d a=%b b=%b",
                                j, f, h, a, b, exp_f[j], exp_h[j], exp_a[j], exp_b[j]);
            end
            step();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || d !== 0 || f != 0.0) begin
            bad++; $display("FAIL basic_done done=%b valid=%b d=%h f=%f exp 1 0 0 0.0", done, out_valid, d, f);
        end
        step();
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_idle done=%b valid=%b exp 0 0", done, out_valid);
        end
    endtask

    task automatic test_stall();
        int  sd = 32'hA5A5_0000;
        int  kexp = 0;
        int  xfers = 0;
        bit  got_done = 0;
        bit  stalled = 0;
        int  prev_d = 0, prev_sa = 0, prev_g1 = 0;
        real prev_f = 0.0;
        kick(4'd4, sd);
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            if (out_valid) begin
                total++;
                if (s.a !== (sd ^ kexp) || d !== sd + kexp || g[0] !== kexp) begin
                    bad++; $display("FAIL stall_rec k=%0d s.a=%h d=%h g0=%h exp %h %h %h",
                                    kexp, s.a, d, g[0], sd ^ kexp, sd + kexp, kexp);
                end
                if (stalled) begin
                    total++;
                    if (d !== prev_d || s.a !== prev_sa || g[1] !== prev_g1 || f != prev_f) begin
                        bad++; $display("FAIL stall_hold cyc=%0d d=%h s.a=%h g1=%h f=%f exp %h %h %h %f",
                                        cyc, d, s.a, g[1], f, prev_d, prev_sa, prev_g1, prev_f);
                    end
                end
            end
            if (done) got_done = 1;
            out_ready = (cyc % 3 == 0);
            stalled   = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                xfers++;
                kexp++;
            end
            prev_d = d; prev_sa = s.a; prev_g1 = g[1]; prev_f = f;
            if (!got_done) step();
        end
        total++;
        if (xfers !== 4 || !got_done) begin
            bad++; $display("FAIL stall_count xfers=%0d done_seen=%0d exp 4 1", xfers, got_done);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_zero();
        kick(4'd0, 55);
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || d !== 0) begin
            bad++; $display("FAIL zero_done done=%b valid=%b d=%h exp 1 0 0", done, out_valid, d);
        end
        step();
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL zero_idle done=%b valid=%b exp 0 0", done, out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        kick(4'd2, 32'h7FFF_FFFF);
        total++;
        if (d !== 32'h7FFF_FFFF || h !== 0) begin
            bad++; $display("FAIL wrap_k0 d=%h h=%0d exp 7fffffff 0", d, h);
        end
        step();
        total++;
        if (d !== 32'h8000_0000 || h !== 3) begin
            bad++; $display("FAIL wrap_k1 d=%h h=%0d exp 80000000 3", d, h);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        kick(4'd5, 200);
        step();
        step();
        total++;
        if (d !== 202) begin
            bad++; $display("FAIL rstmid_pre d=%0d exp 202", d);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || done !== 1'b0 || d !== 0 || e !== 0 || g[0] !== 0 || g[1] !== 0 || f != 0.0) begin
            bad++; $display("FAIL rstmid_async valid=%b done=%b d=%h e=%h g1=%h f=%f exp all 0",
                            out_valid, done, d, e, g[1], f);
        end
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            total++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL rstmid_nodone cyc=%0d done=%b valid=%b exp 0 0", j, done, out_valid);
            end
        end
        kick(4'd3, 300);
        total++;
        if (out_valid !== 1'b1 || d !== 300 || g[0] !== 0) begin
            bad++; $display("FAIL rstmid_restart valid=%b d=%0d g0=%0d exp 1 300 0", out_valid, d, g[0]);
        end
        step();
        step();
        step();
        step();
    endtask

    task automatic test_start_ignored();
        out_ready = 1'b1;
        kick(4'd3, 1000);
        start = 1'b1;
        seed  = 5000;
        count = 4'd1;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (out_valid !== 1'b1 || d !== 1000 + j) begin
                bad++; $display("FAIL ign_run k=%0d valid=%b d=%0d exp 1 %0d", j, out_valid, d, 1000 + j);
            end
            step();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL ign_done done=%b valid=%b exp 1 0", done, out_valid);
        end
        step();
        start = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL ign_idle valid=%b done=%b exp 0 0", out_valid, done);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        kick(4'd1, 7);
        total++;
        if (d !== 7 || out_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_first d=%0d valid=%b exp 7 1", d, out_valid);
        end
        step();
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL b2b_done done=%b exp 1", done);
        end
        start = 1'b1;
        count = 4'd2;
        seed  = 20;
        step();
        total++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_idle valid=%b done=%b exp 0 0", out_valid, done);
        end
        step();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || d !== 20) begin
            bad++; $display("FAIL b2b_second valid=%b d=%0d exp 1 20", out_valid, d);
        end
        step();
        total++;
        if (d !== 21) begin
            bad++; $display("FAIL b2b_k1 d=%0d exp 21", d);
        end
        step();
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_end done=%b valid=%b exp 1 0", done, out_valid);
        end
        step();
    endtask

    task automatic test_max_count();
        out_ready = 1'b1;
        kick(4'd15, 0);
        for (int j = 0; j < 15; j++) begin
            total++;
            if (out_valid !== 1'b1 || g[0] !== j || g[1] !== ~j) begin
                bad++; $display("FAIL max_rec k=%0d valid=%b g0=%0d g1=%h exp 1 %0d %h", j, out_valid, g[0], g[1], j, ~j);
            end
            step();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL max_done done=%b valid=%b exp 1 0", done, out_valid);
        end
        step();
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        count     = '0;
        seed      = 0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_max_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
